// File: rtl/fetch_ctrl_pkg.sv
// Shared types and PC-source encodings for the RV32I fetch controller.
package fetch_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_ISSUE,
    ST_WAIT,
    ST_HOLD,
    ST_DRAIN
  } fetch_state_t;

  localparam logic [1:0] PC_SRC_SEQ_F = 2'd0;
  localparam logic [1:0] PC_SRC_SEQ_E = 2'd1;
  localparam logic [1:0] PC_SRC_ALU   = 2'd2;
  localparam logic [1:0] PC_SRC_BOOT  = 2'd3;

endpackage

// File: rtl/fetch_watchdog.sv
// Watchdog for outstanding imem requests: counts un-acked cycles and raises a
// sticky timeout flag once MAX_WAIT is reached. Waiting continues regardless.
module fetch_watchdog #(
  parameter int MAX_WAIT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic i_active,
  input  logic i_ack,
  output logic o_timeout
);

  localparam logic [7:0] LIMIT = 8'(MAX_WAIT);

  logic [7:0] r_cnt;
  logic       r_timeout;
  logic [7:0] w_cnt_next;

  assign w_cnt_next = r_cnt + 8'd1;
  assign o_timeout  = r_timeout;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt     <= 8'd0;
      r_timeout <= 1'b0;
    end else if (!i_active || i_ack) begin
      r_cnt <= 8'd0;
    end else begin
      // Saturate so a stuck memory never wraps the count back below the limit.
      if (r_cnt != 8'hFF) r_cnt <= w_cnt_next;
      if (r_cnt == 8'hFF || w_cnt_next >= LIMIT) r_timeout <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Fetch-stage sequencer: imem req/ack handshake, PC enable/select, one-entry
// instruction buffer. Optional perf counters under FETCH_CTRL_PERF_EN.
module fetch_controller
  import fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int INSTR_W  = 32,
  parameter int MAX_WAIT = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  PC_F,
  input  logic               stall_D,
  input  logic               redirect_E,
  input  logic [1:0]         redirect_sel_E,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               enable_fetch,
  output logic [1:0]         pc_src_select,
  output logic [INSTR_W-1:0] instr_F,
  output logic               instr_valid_F,
  output logic               fetch_timeout
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall_cycles,
  output logic [31:0]        perf_discards
`endif
);

  fetch_state_t       r_state;
  logic               r_req;
  logic [ADDR_W-1:0]  r_addr;
  logic [INSTR_W-1:0] r_instr;
  logic               r_valid;

  logic w_ack;
  logic w_waiting;

  // An ack is only meaningful while a request is outstanding.
  assign w_ack     = imem_ack && r_req;
  assign w_waiting = (r_state == ST_WAIT) || (r_state == ST_DRAIN);

  assign imem_req      = r_req;
  assign imem_addr     = r_addr;
  assign instr_F       = r_instr;
  assign instr_valid_F = r_valid;

  always_comb begin
    enable_fetch  = 1'b0;
    pc_src_select = PC_SRC_SEQ_F;
    if (r_state == ST_BOOT) begin
      enable_fetch  = 1'b1;
      pc_src_select = PC_SRC_BOOT;
    end else if (redirect_E) begin
      enable_fetch  = 1'b1;
      pc_src_select = redirect_sel_E;
    end else if (r_state == ST_HOLD && !stall_D) begin
      enable_fetch  = 1'b1;
      pc_src_select = PC_SRC_SEQ_F;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_BOOT;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_instr <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_BOOT: r_state <= ST_ISSUE;
        ST_ISSUE: begin
          // On redirect PC_F is stale this cycle; re-issue once the PC reloads.
          if (redirect_E) begin
            r_valid <= 1'b0;
          end else begin
            r_req   <= 1'b1;
            r_addr  <= PC_F;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (redirect_E) begin
            r_valid <= 1'b0;
            if (w_ack) begin
              r_req   <= 1'b0;
              r_state <= ST_ISSUE;
            end else begin
              r_state <= ST_DRAIN;
            end
          end else if (w_ack) begin
            r_req   <= 1'b0;
            r_instr <= imem_rdata;
            r_valid <= 1'b1;
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (redirect_E || !stall_D) begin
            r_valid <= 1'b0;
            r_state <= ST_ISSUE;
          end
        end
        ST_DRAIN: begin
          if (redirect_E) r_valid <= 1'b0;
          if (w_ack) begin
            r_req   <= 1'b0;
            r_state <= ST_ISSUE;
          end
        end
        default: r_state <= ST_BOOT;
      endcase
    end
  end

  fetch_watchdog #(
    .MAX_WAIT (MAX_WAIT)
  ) u_watchdog (
    .clock     (clock),
    .reset     (reset),
    .i_active  (w_waiting),
    .i_ack     (w_ack),
    .o_timeout (fetch_timeout)
  );

`ifdef FETCH_CTRL_PERF_EN
  logic        w_accept;
  logic        w_stall_cyc;
  logic        w_discard;
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_discards;

  assign w_accept    = (r_state == ST_HOLD) && !stall_D && !redirect_E;
  assign w_stall_cyc = (r_state == ST_HOLD) && stall_D;
  assign w_discard   = w_ack && ((r_state == ST_DRAIN) ||
                                 (r_state == ST_WAIT && redirect_E));

  assign perf_fetched      = r_perf_fetched;
  assign perf_stall_cycles = r_perf_stall;
  assign perf_discards     = r_perf_discards;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_perf_fetched  <= '0;
      r_perf_stall    <= '0;
      r_perf_discards <= '0;
    end else begin
      if (w_accept && r_perf_fetched != '1)     r_perf_fetched  <= r_perf_fetched + 32'd1;
      if (w_stall_cyc && r_perf_stall != '1)    r_perf_stall    <= r_perf_stall + 32'd1;
      if (w_discard && r_perf_discards != '1)   r_perf_discards <= r_perf_discards + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: per-cycle vector table plus watchdog
// and reset corner sequences. Models the fetch PC register locally.
module tb_fetch_controller;

  localparam logic [31:0] PC_E4  = 32'h0000_0100;
  localparam logic [31:0] ALU_T  = 32'h0000_0200;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] PC_F;
  logic        stall_D, redirect_E;
  logic [1:0]  redirect_sel_E;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        enable_fetch;
  logic [1:0]  pc_src_select;
  logic [31:0] instr_F;
  logic        instr_valid_F, fetch_timeout;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_fetched, perf_stall_cycles, perf_discards;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  fetch_controller #(.ADDR_W(32), .INSTR_W(32), .MAX_WAIT(8)) dut (
    .clock          (clock),
    .reset          (reset),
    .PC_F           (PC_F),
    .stall_D        (stall_D),
    .redirect_E     (redirect_E),
    .redirect_sel_E (redirect_sel_E),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .enable_fetch   (enable_fetch),
    .pc_src_select  (pc_src_select),
    .instr_F        (instr_F),
    .instr_valid_F  (instr_valid_F),
    .fetch_timeout  (fetch_timeout)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .perf_fetched      (perf_fetched),
    .perf_stall_cycles (perf_stall_cycles),
    .perf_discards     (perf_discards)
`endif
  );

  // Fetch datapath PC register.
  initial PC_F = 32'hFFFF_FFF0;
  always @(posedge clock) begin
    if (enable_fetch) begin
      case (pc_src_select)
        2'd0:    PC_F <= PC_F + 32'd4;
        2'd1:    PC_F <= PC_E4;
        2'd2:    PC_F <= ALU_T;
        default: PC_F <= 32'd0;
      endcase
    end
  end

  typedef struct {
    logic        stall;
    logic        redir;
    logic [1:0]  rsel;
    logic        ack;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic        en;
    logic [1:0]  sel;
    logic        valid;
    logic [31:0] instr;
  } vec_t;

  vec_t tbl [24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    stall_D = 0; redirect_E = 0; redirect_sel_E = 0; imem_ack = 0; imem_rdata = 0;
  endtask

  initial begin
    //           stall rd  rsel  ack rdata          req addr    en sel  vld instr
    tbl[0]  = '{0, 0, 2'd0, 0, 32'h0,         0, 32'h0,   1, 2'd3, 0, 32'h0};        // BOOT
    tbl[1]  = '{0, 0, 2'd0, 0, 32'h0,         0, 32'h0,   0, 2'd0, 0, 32'h0};        // ISSUE
    tbl[2]  = '{0, 0, 2'd0, 1, 32'h00500093,  1, 32'h0,   0, 2'd0, 0, 32'h0};        // WAIT+ack
    tbl[3]  = '{0, 0, 2'd0, 0, 32'h0,         0, 32'h0,   1, 2'd0, 1, 32'h00500093}; // HOLD go
    tbl[4]  = '{0, 0, 2'd0, 0, 32'h0,         0, 32'h0,   0, 2'd0, 0, 32'h00500093}; // ISSUE
    tbl[5]  = '{0, 0, 2'd0, 0, 32'h0,         1, 32'h4,   0, 2'd0, 0, 32'h00500093}; // WAIT
    tbl[6]  = '{0, 0, 2'd0, 1, 32'h00A00113,  1, 32'h4,   0, 2'd0, 0, 32'h00500093}; // WAIT+ack
    tbl[7]  = '{1, 0, 2'd0, 0, 32'h0,         0, 32'h4,   0, 2'd0, 1, 32'h00A00113}; // stall x4
    tbl[8]  = '{1, 0, 2'd0, 0, 32'h0,         0, 32'h4,   0, 2'd0, 1, 32'h00A00113};
    tbl[9]  = '{1, 0, 2'd0, 0, 32'h0,         0, 32'h4,   0, 2'd0, 1, 32'h00A00113};
    tbl[10] = '{1, 0, 2'd0, 0, 32'h0,         0, 32'h4,   0, 2'd0, 1, 32'h00A00113};
    tbl[11] = '{0, 0, 2'd0, 0, 32'h0,         0, 32'h4,   1, 2'd0, 1, 32'h00A00113}; // HOLD go
    tbl[12] = '{0, 0, 2'd0, 0, 32'h0,         0, 32'h4,   0, 2'd0, 0, 32'h00A00113}; // ISSUE
    tbl[13] = '{0, 1, 2'd2, 0, 32'h0,         1, 32'h8,   1, 2'd2, 0, 32'h00A00113}; // WAIT redir
    tbl[14] = '{0, 0, 2'd0, 0, 32'h0,         1, 32'h8,   0, 2'd0, 0, 32'h00A00113}; // DRAIN
    tbl[15] = '{0, 0, 2'd0, 0, 32'h0,         1, 32'h8,   0, 2'd0, 0, 32'h00A00113}; // DRAIN
    tbl[16] = '{0, 0, 2'd0, 1, 32'hDEADBEEF,  1, 32'h8,   0, 2'd0, 0, 32'h00A00113}; // DRAIN ack
    tbl[17] = '{0, 0, 2'd0, 0, 32'h0,         0, 32'h8,   0, 2'd0, 0, 32'h00A00113}; // ISSUE
    tbl[18] = '{0, 1, 2'd1, 1, 32'h11111111,  1, ALU_T,   1, 2'd1, 0, 32'h00A00113}; // ack+redir
    tbl[19] = '{0, 0, 2'd0, 0, 32'h0,         0, ALU_T,   0, 2'd0, 0, 32'h00A00113}; // ISSUE
    tbl[20] = '{0, 0, 2'd0, 1, 32'h22222222,  1, PC_E4,   0, 2'd0, 0, 32'h00A00113}; // WAIT+ack
    tbl[21] = '{1, 1, 2'd2, 0, 32'h0,         0, PC_E4,   1, 2'd2, 1, 32'h22222222}; // redir>stall
    tbl[22] = '{0, 0, 2'd0, 0, 32'h0,         0, PC_E4,   0, 2'd0, 0, 32'h22222222}; // ISSUE
    tbl[23] = '{0, 0, 2'd0, 0, 32'h0,         1, ALU_T,   0, 2'd0, 0, 32'h22222222}; // WAIT

    idle();
    reset = 1;
    repeat (2) step();
    chk("rst_req",     32'(imem_req), 32'd0);
    chk("rst_addr",    imem_addr, 32'd0);
    chk("rst_valid",   32'(instr_valid_F), 32'd0);
    chk("rst_instr",   instr_F, 32'd0);
    chk("rst_timeout", 32'(fetch_timeout), 32'd0);
    reset = 0;

    for (int i = 0; i < 24; i++) begin
      stall_D = tbl[i].stall; redirect_E = tbl[i].redir; redirect_sel_E = tbl[i].rsel;
      imem_ack = tbl[i].ack; imem_rdata = tbl[i].rdata;
      #1;
      chk($sformatf("v%0d_req", i),   32'(imem_req), 32'(tbl[i].req));
      chk($sformatf("v%0d_addr", i),  imem_addr, tbl[i].addr);
      chk($sformatf("v%0d_en", i),    32'(enable_fetch), 32'(tbl[i].en));
      chk($sformatf("v%0d_sel", i),   32'(pc_src_select), 32'(tbl[i].sel));
      chk($sformatf("v%0d_valid", i), 32'(instr_valid_F), 32'(tbl[i].valid));
      chk($sformatf("v%0d_instr", i), instr_F, tbl[i].instr);
      step();
    end

`ifdef FETCH_CTRL_PERF_EN
    chk("perf_fetched",  perf_fetched, 32'd2);
    chk("perf_stall",    perf_stall_cycles, 32'd5);
    chk("perf_discards", perf_discards, 32'd2);
`endif

    // One WAIT cycle already elapsed; timeout must appear after the 8th.
    idle();
    for (int j = 2; j <= 10; j++) begin
      step();
      chk($sformatf("wd_timeout_%0d", j), 32'(fetch_timeout), (j >= 8) ? 32'd1 : 32'd0);
      chk($sformatf("wd_req_%0d", j), 32'(imem_req), 32'd1);
    end
    imem_ack = 1; imem_rdata = 32'h44444444;
    step();
    idle();
    chk("wd_late_valid",  32'(instr_valid_F), 32'd1);
    chk("wd_late_instr",  instr_F, 32'h44444444);
    chk("wd_sticky",      32'(fetch_timeout), 32'd1);
    step();
    chk("wd_sticky2",     32'(fetch_timeout), 32'd1);

    // Reset clears timeout; acks while no request is outstanding are ignored.
    reset = 1; imem_ack = 1; imem_rdata = 32'h33333333;
    step();
    chk("rst2_timeout", 32'(fetch_timeout), 32'd0);
    chk("rst2_req",     32'(imem_req), 32'd0);
    reset = 0;
    step();
    chk("late_ack_valid", 32'(instr_valid_F), 32'd0);
    chk("late_ack_req",   32'(imem_req), 32'd0);
    imem_ack = 0;
    step();
    chk("reboot_req",   32'(imem_req), 32'd1);
    chk("reboot_addr",  imem_addr, 32'd0);
    chk("reboot_valid", 32'(instr_valid_F), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
